// File: rtl/trace_cmp_pkg.sv
// Shared types and helpers for the lockstep trace comparator.
//   state_t    : comparator run/halt state
//   DEF_WIDTH  : default trace word width
//   lowest_set : index of the lowest set bit of a channel mask (0 if none)
package trace_cmp_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALT_MM = 2'd1,
    HALT_OV = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 36;
  localparam int unsigned MAX_NCH   = 8;
  localparam int unsigned IDX_W     = 3;

  // Reference channel selection: lowest enabled channel wins.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_NCH-1:0] mask);
    lowest_set = '0;
    for (int i = MAX_NCH - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO absorbing per-channel trace skew.
//   clk, resetn : clock, synchronous active-low reset
//   push, din   : write request and data (ignored when full unless popping)
//   pop         : remove head (ignored when empty)
//   head        : current head word, combinational from storage
//   full, empty : occupancy flags
//   count       : current occupancy, 0..DEPTH
module trace_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; only words behind valid pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/trace_lockstep_cmp.sv
// Lockstep trace comparator: buffers each core's trace stream, retires
// entries in order once every enabled channel holds one, compares them to
// the lowest enabled channel and halts on the first divergence or overflow.
//   clk, resetn            : clock, synchronous active-low reset
//   chan_en                : channel enable mask, sampled during reset
//   trace_valid/trace_data : per-channel trace strobe and word
//   cmp_valid, cmp_count   : retire pulse and retired-entry counter
//   mismatch, overflow     : sticky error flags
//   err_mask/ref/index     : snapshot of the first divergence
//   skew_max               : peak FIFO occupancy seen
module trace_lockstep_cmp
  import trace_cmp_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NCH-1:0]         chan_en,
  input  logic [NCH-1:0]         trace_valid,
  input  logic [NCH*WIDTH-1:0]   trace_data,
  output logic                   cmp_valid,
  output logic [CNT_W-1:0]       cmp_count,
  output logic                   mismatch,
  output logic                   overflow,
  output logic [NCH-1:0]         err_mask,
  output logic [WIDTH-1:0]       err_ref,
  output logic [CNT_W-1:0]       err_index,
  output logic [$clog2(DEPTH):0] skew_max
);

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  state_t             state, state_nx;
  logic [NCH-1:0]     en_q;
  logic [NCH-1:0]     push, pop, full, empty;
  logic [WIDTH-1:0]   head   [NCH];
  logic [OCC_W-1:0]   occ    [NCH];
  logic [OCC_W-1:0]   occ_nx [NCH];
  logic [IDX_W-1:0]   ref_idx;
  logic [WIDTH-1:0]   ref_head;
  logic [NCH-1:0]     diff;
  logic               run, retire, ovf;

  logic               cmp_valid_nx, mismatch_nx, overflow_nx;
  logic [CNT_W-1:0]   cmp_count_nx, err_index_nx;
  logic [NCH-1:0]     err_mask_nx;
  logic [WIDTH-1:0]   err_ref_nx;
  logic [OCC_W-1:0]   skew_nx;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    trace_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push[g]),
      .pop    (pop[g]),
      .din    (trace_data[g*WIDTH +: WIDTH]),
      .head   (head[g]),
      .full   (full[g]),
      .empty  (empty[g]),
      .count  (occ[g])
    );
  end

  assign ref_idx = lowest_set(MAX_NCH'(en_q));

  // Retire/compare datapath: disabled channels count as always ready.
  always_comb begin
    run      = (state == RUN);
    retire   = run && (en_q != '0) && (&(~empty | ~en_q));
    push     = trace_valid & en_q & {NCH{run}};
    pop      = en_q & {NCH{retire}};
    ref_head = '0;
    diff     = '0;
    ovf      = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (IDX_W'(i) == ref_idx) ref_head = head[i];
    end
    for (int i = 0; i < NCH; i++) begin
      diff[i]   = retire && en_q[i] && (head[i] != ref_head);
      if (push[i] && full[i] && !pop[i]) ovf = 1'b1;
      occ_nx[i] = occ[i] + OCC_W'(push[i] & (~full[i] | pop[i])) - OCC_W'(pop[i]);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx     = state;
    cmp_valid_nx = 1'b0;
    cmp_count_nx = cmp_count;
    mismatch_nx  = mismatch;
    overflow_nx  = overflow;
    err_mask_nx  = err_mask;
    err_ref_nx   = err_ref;
    err_index_nx = err_index;
    skew_nx      = skew_max;
    if (run) begin
      for (int i = 0; i < NCH; i++) begin
        if (en_q[i] && (occ_nx[i] > skew_nx)) skew_nx = occ_nx[i];
      end
      if (ovf) begin
        overflow_nx = 1'b1;
        state_nx    = HALT_OV;
      end
      if (retire) begin
        cmp_valid_nx = 1'b1;
        cmp_count_nx = cmp_count + CNT_W'(1);
        // Mismatch takes precedence over overflow for the halt state.
        if (diff != '0) begin
          mismatch_nx  = 1'b1;
          err_mask_nx  = diff;
          err_ref_nx   = ref_head;
          err_index_nx = cmp_count;
          state_nx     = HALT_MM;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= RUN;
      en_q      <= chan_en;
      cmp_valid <= 1'b0;
      cmp_count <= '0;
      mismatch  <= 1'b0;
      overflow  <= 1'b0;
      err_mask  <= '0;
      err_ref   <= '0;
      err_index <= '0;
      skew_max  <= '0;
    end else begin
      state     <= state_nx;
      cmp_valid <= cmp_valid_nx;
      cmp_count <= cmp_count_nx;
      mismatch  <= mismatch_nx;
      overflow  <= overflow_nx;
      err_mask  <= err_mask_nx;
      err_ref   <= err_ref_nx;
      err_index <= err_index_nx;
      skew_max  <= skew_nx;
    end
  end

endmodule

// File: tb/tb_trace_lockstep_cmp.sv
// Self-checking bench for trace_lockstep_cmp (NCH=3, DEPTH=4, CNT_W=4).
// A queue-based reference model is checked every cycle, plus a directed
// vector table and hand-written corner sequences with fixed expectations.
module tb_trace_lockstep_cmp;

  localparam int unsigned NCH   = 3;
  localparam int unsigned WIDTH = 36;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SKW   = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [NCH-1:0]       chan_en;
  logic [NCH-1:0]       trace_valid;
  logic [NCH*WIDTH-1:0] trace_data;
  logic                 cmp_valid;
  logic [CNT_W-1:0]     cmp_count;
  logic                 mismatch;
  logic                 overflow;
  logic [NCH-1:0]       err_mask;
  logic [WIDTH-1:0]     err_ref;
  logic [CNT_W-1:0]     err_index;
  logic [SKW-1:0]       skew_max;

  always #5 clk = ~clk;

  trace_lockstep_cmp #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .chan_en     (chan_en),
    .trace_valid (trace_valid),
    .trace_data  (trace_data),
    .cmp_valid   (cmp_valid),
    .cmp_count   (cmp_count),
    .mismatch    (mismatch),
    .overflow    (overflow),
    .err_mask    (err_mask),
    .err_ref     (err_ref),
    .err_index   (err_index),
    .skew_max    (skew_max)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: one queue per channel plus result registers.
  logic [WIDTH-1:0] mq [NCH][$];
  logic [NCH-1:0]   m_en;
  bit               m_mm, m_ov, m_cv;
  logic [CNT_W-1:0] m_cnt, m_eidx;
  logic [NCH-1:0]   m_emask;
  logic [WIDTH-1:0] m_eref;
  int               m_skew;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one clock edge of the behavioural rules to the model.
  task automatic model_edge();
    logic [NCH-1:0]   diff;
    logic [WIDTH-1:0] rword;
    bit               retire, ovf;
    int               rf;
    if (!resetn) begin
      for (int i = 0; i < NCH; i++) mq[i].delete();
      m_en = chan_en; m_mm = 0; m_ov = 0; m_cv = 0;
      m_cnt = '0; m_emask = '0; m_eref = '0; m_eidx = '0; m_skew = 0;
      return;
    end
    m_cv = 0;
    if (m_mm || m_ov) return;
    retire = (m_en != '0);
    rf = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m_en[i]) begin
        rf = i;
        if (mq[i].size() == 0) retire = 0;
      end
    end
    diff = '0; ovf = 0; rword = '0;
    if (retire) begin
      rword = mq[rf][0];
      for (int i = 0; i < NCH; i++)
        if (m_en[i] && mq[i][0] != rword) diff[i] = 1'b1;
    end
    for (int i = 0; i < NCH; i++) begin
      if (!m_en[i]) continue;
      if (trace_valid[i] && mq[i].size() == DEPTH && !retire) ovf = 1;
      if (retire) void'(mq[i].pop_front());
      if (trace_valid[i] && mq[i].size() < DEPTH) mq[i].push_back(trace_data[i*WIDTH +: WIDTH]);
      if (mq[i].size() > m_skew) m_skew = mq[i].size();
    end
    if (retire) begin
      m_cv = 1;
      if (diff != '0) begin
        m_mm = 1; m_emask = diff; m_eref = rword; m_eidx = m_cnt;
      end
      m_cnt = m_cnt + CNT_W'(1);
    end
    if (ovf) m_ov = 1;
  endtask

  task automatic compare_model();
    chk("cmp_valid", 64'(cmp_valid), 64'(m_cv));
    chk("cmp_count", 64'(cmp_count), 64'(m_cnt));
    chk("mismatch",  64'(mismatch),  64'(m_mm));
    chk("overflow",  64'(overflow),  64'(m_ov));
    chk("err_mask",  64'(err_mask),  64'(m_emask));
    chk("err_ref",   64'(err_ref),   64'(m_eref));
    chk("err_index", 64'(err_index), 64'(m_eidx));
    chk("skew_max",  64'(skew_max),  64'(m_skew));
  endtask

  task automatic cycle(input logic [NCH-1:0] v, input logic [NCH*WIDTH-1:0] d);
    trace_valid = v;
    trace_data  = d;
    @(posedge clk);
    model_edge();
    #1 compare_model();
  endtask

  function automatic logic [NCH*WIDTH-1:0] d3(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] c);
    return {c, b, a};
  endfunction

  // Reset cycle with strobes asserted (they must be dropped), then scramble
  // chan_en to show it is only sampled during reset.
  task automatic do_reset(input logic [NCH-1:0] en);
    resetn  = 1'b0;
    chan_en = en;
    cycle('1, d3(36'h5, 36'h6, 36'h7));
    resetn  = 1'b1;
    chan_en = NCH'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".cmp_valid"}, 64'(cmp_valid), 64'd0);
    chk({tag, ".cmp_count"}, 64'(cmp_count), 64'd0);
    chk({tag, ".mismatch"},  64'(mismatch),  64'd0);
    chk({tag, ".overflow"},  64'(overflow),  64'd0);
    chk({tag, ".err_mask"},  64'(err_mask),  64'd0);
    chk({tag, ".err_ref"},   64'(err_ref),   64'd0);
    chk({tag, ".err_index"}, 64'(err_index), 64'd0);
    chk({tag, ".skew_max"},  64'(skew_max),  64'd0);
  endtask

  typedef struct {
    logic [NCH-1:0]   v;
    logic [WIDTH-1:0] d0, d1, d2;
    bit               cv;
    logic [CNT_W-1:0] cnt;
    bit               mm;
    logic [NCH-1:0]   emask;
    logic [WIDTH-1:0] eref;
    logic [CNT_W-1:0] eidx;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [WIDTH-1:0] base;
    int               idx [NCH];
    logic [NCH-1:0]   v;
    logic [NCH*WIDTH-1:0] d;
    logic [WIDTH-1:0] w;

    // Three-channel divergence on the third entry, then halted.
    tbl[0] = '{3'b111, 36'h1, 36'h1, 36'h1, 1'b0, 4'd0, 1'b0, 3'b000, 36'h0, 4'd0};
    tbl[1] = '{3'b111, 36'h2, 36'h2, 36'h2, 1'b1, 4'd1, 1'b0, 3'b000, 36'h0, 4'd0};
    tbl[2] = '{3'b111, 36'hA, 36'hA, 36'hB, 1'b1, 4'd2, 1'b0, 3'b000, 36'h0, 4'd0};
    tbl[3] = '{3'b000, 36'h0, 36'h0, 36'h0, 1'b1, 4'd3, 1'b1, 3'b100, 36'hA, 4'd2};
    tbl[4] = '{3'b111, 36'h5, 36'h5, 36'h5, 1'b0, 4'd3, 1'b1, 3'b100, 36'hA, 4'd2};
    tbl[5] = '{3'b111, 36'h6, 36'h6, 36'h6, 1'b0, 4'd3, 1'b1, 3'b100, 36'hA, 4'd2};

    resetn = 1'b0; chan_en = '0; trace_valid = '0; trace_data = '0;
    repeat (2) @(posedge clk);

    do_reset(3'b111);
    chk_all_zero("reset");
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].v, d3(tbl[i].d0, tbl[i].d1, tbl[i].d2));
      chk($sformatf("tbl%0d.cmp_valid", i), 64'(cmp_valid), 64'(tbl[i].cv));
      chk($sformatf("tbl%0d.cmp_count", i), 64'(cmp_count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d.mismatch", i),  64'(mismatch),  64'(tbl[i].mm));
      chk($sformatf("tbl%0d.err_mask", i),  64'(err_mask),  64'(tbl[i].emask));
      chk($sformatf("tbl%0d.err_ref", i),   64'(err_ref),   64'(tbl[i].eref));
      chk($sformatf("tbl%0d.err_index", i), 64'(err_index), 64'(tbl[i].eidx));
    end

    // Two channels in perfect lockstep.
    do_reset(3'b011);
    for (int k = 1; k <= 3; k++) cycle(3'b011, d3(WIDTH'(k), WIDTH'(k), 36'h0));
    cycle('0, '0);
    chk("sync.cmp_count", 64'(cmp_count), 64'd3);
    chk("sync.mismatch",  64'(mismatch),  64'd0);
    chk("sync.skew_max",  64'(skew_max),  64'd1);

    // Channel 1 lags by 3 cycles: fills channel 0 to DEPTH with push+pop on full.
    do_reset(3'b011);
    for (int c = 0; c < 9; c++) begin
      v = {1'b0, (c >= 3), (c < 6)};
      cycle(v, d3(WIDTH'(c + 1), WIDTH'(c - 2), 36'h0));
    end
    repeat (2) cycle('0, '0);
    chk("lag.cmp_count", 64'(cmp_count), 64'd6);
    chk("lag.skew_max",  64'(skew_max),  64'd4);
    chk("lag.overflow",  64'(overflow),  64'd0);
    chk("lag.mismatch",  64'(mismatch),  64'd0);

    // Channel 1 silent: fifth push into a full FIFO overflows.
    do_reset(3'b011);
    for (int k = 1; k <= 5; k++) begin
      cycle(3'b001, d3(WIDTH'(k), 36'h0, 36'h0));
      chk($sformatf("ovf%0d.overflow", k), 64'(overflow), 64'(k == 5));
    end
    cycle(3'b011, d3(36'h9, 36'h1, 36'h0));
    chk("ovf.cmp_count", 64'(cmp_count), 64'd0);
    chk("ovf.cmp_valid", 64'(cmp_valid), 64'd0);

    // Channel 0 disabled and sending garbage: channel 1 is the reference.
    do_reset(3'b110);
    for (int k = 0; k < 6; k++)
      cycle(3'b111, d3(WIDTH'($urandom), WIDTH'(k + 16), WIDTH'(k + 16)));
    cycle('0, '0);
    chk("en110.mismatch",  64'(mismatch),  64'd0);
    chk("en110.cmp_count", 64'(cmp_count), 64'd6);

    // No channel enabled: nothing pushes or retires.
    do_reset(3'b000);
    repeat (3) cycle(3'b111, d3(36'h1, 36'h2, 36'h3));
    chk("en000.cmp_count", 64'(cmp_count), 64'd0);
    chk("en000.skew_max",  64'(skew_max),  64'd0);

    // Counter wraps at 2^CNT_W, then reset mid-stream clears everything.
    do_reset(3'b111);
    for (int k = 0; k < 17; k++) cycle(3'b111, d3(WIDTH'(k), WIDTH'(k), WIDTH'(k)));
    cycle('0, '0);
    chk("wrap.cmp_count", 64'(cmp_count), 64'd1);
    chk("wrap.mismatch",  64'(mismatch),  64'd0);
    repeat (3) cycle(3'b111, d3(36'h3, 36'h3, 36'h4));
    resetn = 1'b0;
    cycle(3'b111, d3(36'h1, 36'h1, 36'h1));
    chk_all_zero("midreset");
    resetn = 1'b1;

    // Randomized streams from a shared program, occasional corruption.
    for (int r = 0; r < 14; r++) begin
      do_reset(NCH'($urandom));
      base = {4'h0, 32'($urandom)};
      for (int i = 0; i < NCH; i++) idx[i] = 0;
      for (int c = 0; c < 150; c++) begin
        for (int i = 0; i < NCH; i++) begin
          v[i] = ($urandom_range(0, 99) < 60);
          w = base + WIDTH'(idx[i]) * 36'h9E3779B1;
          if ($urandom_range(0, 299) == 0) w = w ^ 36'h1;
          d[i*WIDTH +: WIDTH] = w;
          if (v[i]) idx[i]++;
        end
        cycle(v, d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
